instr_fetch_unit: RTL and testbench

- Reader side of the instruction RAM. Owns the program counter (PC) and drives the 9-bit instruction address.
- Captures each 16-bit word one cycle after the address is issued. The word is split as opcode[15:10] and operand[9:0].
- Presents the instruction to the control unit with a valid/ready handshake.
- Resolves JUMPZ/JUMPNZ against the Z flag and halts on the end-of-program opcode.

---
 rtl/instr_fetch_unit_pkg.sv | 29 ++
 rtl/instr_fetch_unit_next_pc_logic.sv | 26 ++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Processor-wide constants: ISA opcodes, datapath widths and the fetch-state encoding.
package instr_fetch_unit_pkg;

    localparam int unsigned ISA_ADDR_W  = 9;
    localparam int unsigned ISA_INSTR_W = 16;
    localparam int unsigned ISA_OPC_W   = 6;
    localparam int unsigned ISA_OPND_W  = ISA_INSTR_W - ISA_OPC_W;

    localparam logic [ISA_OPC_W-1:0] OPC_FETCH  = 6'd0;
    localparam logic [ISA_OPC_W-1:0] OPC_LOAD   = 6'd1;
    localparam logic [ISA_OPC_W-1:0] OPC_STORE  = 6'd2;
    localparam logic [ISA_OPC_W-1:0] OPC_ADD    = 6'd3;
    localparam logic [ISA_OPC_W-1:0] OPC_SUB    = 6'd4;
    localparam logic [ISA_OPC_W-1:0] OPC_AND    = 6'd5;
    localparam logic [ISA_OPC_W-1:0] OPC_OR     = 6'd6;
    localparam logic [ISA_OPC_W-1:0] OPC_XOR    = 6'd7;
    localparam logic [ISA_OPC_W-1:0] OPC_NOP    = 6'd46;
    localparam logic [ISA_OPC_W-1:0] OPC_JUMPNZ = 6'd47;
    localparam logic [ISA_OPC_W-1:0] OPC_JUMPZ  = 6'd52;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StDispatch,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_next_pc_logic.sv
// Combinational branch resolution: picks the next PC and flags jumps whose target is out of range.
module next_pc_logic
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = ISA_ADDR_W,
    parameter int unsigned OPC_W  = ISA_OPC_W,
    parameter int unsigned OPND_W = ISA_OPND_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [OPND_W-1:0] operand,
    input  logic              z_flag,
    output logic [ADDR_W-1:0] next_pc,
    output logic              jump_taken,
    output logic              bad_target_hit
);

    always_comb begin
        jump_taken = ((opcode == OPC_W'(OPC_JUMPZ))  &&  z_flag) ||
                     ((opcode == OPC_W'(OPC_JUMPNZ)) && !z_flag);
        // The top operand bit lies outside the address space.
        bad_target_hit = jump_taken && operand[OPND_W-1];
        next_pc        = jump_taken ? operand[ADDR_W-1:0] : pc + ADDR_W'(1);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the instruction RAM and hands words to control via valid/ready.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned          ADDR_W      = ISA_ADDR_W,
    parameter int unsigned          INSTR_W     = ISA_INSTR_W,
    parameter int unsigned          OPC_W       = ISA_OPC_W,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
    parameter logic [OPC_W-1:0]     HALT_OPCODE = OPC_NOP
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_data,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [OPC_W-1:0]           opcode,
    output logic [INSTR_W-OPC_W-1:0]   operand,
    input  logic                       z_flag,
    output logic [ADDR_W-1:0]          pc,
    output logic                       busy,
    output logic                       halted,
    output logic                       bad_target
);

    localparam int unsigned OPND_W = INSTR_W - OPC_W;

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                bad_target_q, bad_target_d;

    logic [ADDR_W-1:0]   next_pc;
    logic                jump_taken;
    logic                bad_target_hit;

    next_pc_logic #(
        .ADDR_W (ADDR_W),
        .OPC_W  (OPC_W),
        .OPND_W (OPND_W)
    ) u_next_pc_logic (
        .pc             (pc_q),
        .opcode         (opcode),
        .operand        (operand),
        .z_flag         (z_flag),
        .next_pc        (next_pc),
        .jump_taken     (jump_taken),
        .bad_target_hit (bad_target_hit)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        bad_target_d = bad_target_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = RESET_PC;
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                ir_d    = imem_data;
                state_d = StDispatch;
            end
            StDispatch: begin
                if (instr_ready) begin
                    if (opcode == HALT_OPCODE) begin
                        state_d = StHalt;
                    end else if (jump_taken && bad_target_hit) begin
                        // PC stays on the offending jump for diagnosis.
                        bad_target_d = 1'b1;
                        state_d      = StHalt;
                    end else begin
                        pc_d    = next_pc;
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                if (start) begin
                    pc_d         = RESET_PC;
                    bad_target_d = 1'b0;
                    state_d      = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            bad_target_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            bad_target_q <= bad_target_d;
        end
    end

    // All outputs come from flops, so ready/z never reach valid or the instruction fields.
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign opcode      = ir_q[INSTR_W-1 -: OPC_W];
    assign operand     = ir_q[OPND_W-1:0];
    assign instr_valid = (state_q == StDispatch);
    assign busy        = (state_q == StFetch) || (state_q == StWait) || (state_q == StDispatch);
    assign halted      = (state_q == StHalt);
    assign bad_target  = bad_target_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver walks a small program, a monitor checks accepts.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  imem_addr;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  opcode;
    logic [9:0]  operand;
    logic        z_flag;
    logic [8:0]  pc;
    logic        busy;
    logic        halted;
    logic        bad_target;

    logic [15:0] rom [0:511];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [8:0] pc;
        logic [5:0] opc;
        logic [9:0] opnd;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .z_flag      (z_flag),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .bad_target  (bad_target)
    );

    // Registered-read RAM model with one cycle of latency.
    always @(posedge clk) imem_data <= rom[imem_addr];

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every accepted instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_accept", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", int'(pc), int'(e.pc));
                check("sb_opcode", int'(opcode), int'(e.opc));
                check("sb_operand", int'(operand), int'(e.opnd));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Entered at posedge+1 with the DUT in FETCH for epc.
    task automatic issue(input logic [8:0] epc, input logic [5:0] eopc, input logic [9:0] eopnd,
                         input bit z, input int stall, input bit busy_start);
        exp_t e;
        int n;
        e.pc = epc; e.opc = eopc; e.opnd = eopnd;
        exp_q.push_back(e);
        check("fetch_addr", int'(imem_addr), int'(epc));
        n = 0;
        while (!instr_valid && n < 20) begin
            if (busy_start && n == 0) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("valid_latency", n, 2);
        for (int i = 0; i < stall; i++) begin
            z_flag = ~z_flag;
            @(posedge clk); #1;
            check("stall_valid", int'(instr_valid), 1);
            check("stall_opcode", int'(opcode), int'(eopc));
            check("stall_operand", int'(operand), int'(eopnd));
            check("stall_addr", int'(imem_addr), int'(epc));
        end
        instr_ready = 1'b1;
        z_flag      = z;
        @(posedge clk); #1;
        instr_ready = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
        rom[0]   = {OPC_LOAD,   10'd5};
        rom[1]   = {OPC_ADD,    10'd7};
        rom[2]   = {OPC_JUMPZ,  10'd151};
        rom[3]   = {OPC_JUMPNZ, 10'd827};
        rom[4]   = {OPC_JUMPZ,  10'd511};
        rom[151] = {OPC_JUMPZ,  10'd179};
        rom[152] = {OPC_JUMPNZ, 10'd184};
        rom[179] = {OPC_JUMPNZ, 10'd151};
        rom[184] = {OPC_JUMPNZ, 10'd63};
        rom[185] = {OPC_NOP,    10'd0};
        rom[511] = {OPC_ADD,    10'd1};

        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0; z_flag = 1'b0;
        @(posedge clk); #1;
        check("rst_addr", int'(imem_addr), 0);
        check("rst_valid", int'(instr_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_bad", int'(bad_target), 0);
        check("rst_opcode", int'(opcode), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", int'(busy), 0);

        // Sequential fetch, conditional jumps, backpressure, halt.
        pulse_start();
        check("start_busy", int'(busy), 1);
        issue(9'd0,   OPC_LOAD,   10'd5,   1'b0, 0, 1'b0);
        issue(9'd1,   OPC_ADD,    10'd7,   1'b0, 0, 1'b1);
        issue(9'd2,   OPC_JUMPZ,  10'd151, 1'b1, 0, 1'b0);
        issue(9'd151, OPC_JUMPZ,  10'd179, 1'b1, 0, 1'b0);
        issue(9'd179, OPC_JUMPNZ, 10'd151, 1'b0, 0, 1'b0);
        issue(9'd151, OPC_JUMPZ,  10'd179, 1'b0, 0, 1'b0);
        issue(9'd152, OPC_JUMPNZ, 10'd184, 1'b0, 0, 1'b0);
        issue(9'd184, OPC_JUMPNZ, 10'd63,  1'b1, 5, 1'b1);
        issue(9'd185, OPC_NOP,    10'd0,   1'b0, 0, 1'b0);
        check("halt_halted", int'(halted), 1);
        check("halt_valid", int'(instr_valid), 0);
        check("halt_busy", int'(busy), 0);
        check("halt_pc", int'(pc), 185);
        @(posedge clk); #1;
        check("halt_stays", int'(halted), 1);

        // Restart from HALT, then a taken jump to an out-of-range target.
        pulse_start();
        check("restart_addr", int'(imem_addr), 0);
        check("restart_halted", int'(halted), 0);
        issue(9'd0, OPC_LOAD,   10'd5,   1'b1, 0, 1'b0);
        issue(9'd1, OPC_ADD,    10'd7,   1'b1, 0, 1'b0);
        issue(9'd2, OPC_JUMPZ,  10'd151, 1'b0, 0, 1'b0);
        issue(9'd3, OPC_JUMPNZ, 10'd827, 1'b0, 0, 1'b0);
        check("bad_flag", int'(bad_target), 1);
        check("bad_halted", int'(halted), 1);
        check("bad_pc", int'(pc), 3);

        // Restart clears bad_target; reach 511 and reset mid-DISPATCH.
        pulse_start();
        check("bad_cleared", int'(bad_target), 0);
        issue(9'd0, OPC_LOAD,   10'd5,   1'b0, 0, 1'b0);
        issue(9'd1, OPC_ADD,    10'd7,   1'b0, 0, 1'b0);
        issue(9'd2, OPC_JUMPZ,  10'd151, 1'b0, 0, 1'b0);
        issue(9'd3, OPC_JUMPNZ, 10'd827, 1'b1, 0, 1'b0);
        issue(9'd4, OPC_JUMPZ,  10'd511, 1'b1, 0, 1'b0);
        n = 0;
        while (!instr_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_rst_valid", int'(instr_valid), 1);
        check("pre_rst_pc", int'(pc), 511);
        instr_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(instr_valid), 0);
        check("arst_pc", int'(pc), 0);
        check("arst_addr", int'(imem_addr), 0);
        check("arst_opcode", int'(opcode), 0);
        check("arst_operand", int'(operand), 0);
        check("arst_busy", int'(busy), 0);
        @(posedge clk); #1;
        instr_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", int'(busy), 0);

        // PC wrap from 511 to 0.
        pulse_start();
        issue(9'd0,   OPC_LOAD,   10'd5,   1'b0, 0, 1'b0);
        issue(9'd1,   OPC_ADD,    10'd7,   1'b0, 0, 1'b0);
        issue(9'd2,   OPC_JUMPZ,  10'd151, 1'b0, 0, 1'b0);
        issue(9'd3,   OPC_JUMPNZ, 10'd827, 1'b1, 0, 1'b0);
        issue(9'd4,   OPC_JUMPZ,  10'd511, 1'b1, 0, 1'b0);
        issue(9'd511, OPC_ADD,    10'd1,   1'b0, 0, 1'b0);
        issue(9'd0,   OPC_LOAD,   10'd5,   1'b0, 0, 1'b0);

        @(posedge clk); #1;
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
